// File: rtl/number_assembler.sv
// Assembles runs of classified ASCII decimal digits into unsigned WIDTH-bit values.
// Runs end at a separator byte or flush; malformed or overflowing runs are flagged.
module number_assembler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       data_in,
    input  logic             is_number,
    input  logic             is_white,
    input  logic             flush,
    output logic [WIDTH-1:0] value_out,
    output logic             value_valid,
    output logic             err_overflow,
    output logic             err_char,
    output logic             busy
);

    localparam int unsigned ACC_W = WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DISCARD
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic             ovf_seen, ovf_nxt;
    logic [WIDTH-1:0] value_nxt;
    logic             valid_nxt, err_ovf_nxt, err_chr_nxt;

    logic             is_digit_c, is_sep_c, is_bad_c;
    logic [3:0]       digit_c;
    logic [ACC_W-1:0] prod_c;
    logic             prod_ovf_c;

    // A byte flagged both digit and separator is treated as a digit.
    assign is_digit_c = en & is_number;
    assign is_sep_c   = en & is_white & ~is_number;
    assign is_bad_c   = en & ~is_white & ~is_number;
    assign digit_c    = 4'(data_in - 8'd48);
    assign prod_c     = ACC_W'(acc) * ACC_W'(10) + ACC_W'(digit_c);
    assign prod_ovf_c = |prod_c[ACC_W-1:WIDTH];

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            ovf_seen     <= 1'b0;
            value_out    <= '0;
            value_valid  <= 1'b0;
            err_overflow <= 1'b0;
            err_char     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            acc          <= acc_nxt;
            ovf_seen     <= ovf_nxt;
            value_out    <= value_nxt;
            value_valid  <= valid_nxt;
            err_overflow <= err_ovf_nxt;
            err_char     <= err_chr_nxt;
            busy         <= (state_nxt != IDLE);
        end
    end

    // Next state: process the byte first, then apply flush as a trailing separator.
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        ovf_nxt     = ovf_seen;
        value_nxt   = value_out;
        valid_nxt   = 1'b0;
        err_ovf_nxt = 1'b0;
        err_chr_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (is_digit_c) begin
                    acc_nxt   = WIDTH'(digit_c);
                    state_nxt = ACCUM;
                end else if (is_bad_c) begin
                    ovf_nxt   = 1'b0;
                    state_nxt = DISCARD;
                end
            end
            ACCUM: begin
                if (is_digit_c) begin
                    if (prod_ovf_c) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = DISCARD;
                    end else begin
                        acc_nxt = WIDTH'(prod_c);
                    end
                end else if (is_sep_c) begin
                    value_nxt = acc;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (is_bad_c) begin
                    ovf_nxt   = 1'b0;
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (is_sep_c) begin
                    err_ovf_nxt = ovf_seen;
                    err_chr_nxt = ~ovf_seen;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A separator byte already returned to IDLE, so pulses stay exclusive.
        if (flush) begin
            if (state_nxt == ACCUM) begin
                value_nxt = acc_nxt;
                valid_nxt = 1'b1;
                state_nxt = IDLE;
            end else if (state_nxt == DISCARD) begin
                err_ovf_nxt = ovf_nxt;
                err_chr_nxt = ~ovf_nxt;
                state_nxt   = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_number_assembler.sv
// Directed bench for number_assembler: each step queues its expected outcome,
// which is popped and compared once the clock edge has produced the DUT response.
module tb_number_assembler;

    localparam int unsigned WIDTH = 16;

    typedef enum logic [1:0] {K_NONE, K_VAL, K_OVF, K_CHR} kind_t;

    typedef struct {
        kind_t       kind;
        int unsigned value;
        logic        busy;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [7:0]       data_in;
    logic             is_number;
    logic             is_white;
    logic             flush;
    logic [WIDTH-1:0] value_out;
    logic             value_valid;
    logic             err_overflow;
    logic             err_char;
    logic             busy;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    number_assembler #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .data_in      (data_in),
        .is_number    (is_number),
        .is_white     (is_white),
        .flush        (flush),
        .value_out    (value_out),
        .value_valid  (value_valid),
        .err_overflow (err_overflow),
        .err_char     (err_char),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Pop the oldest expectation and compare it against the current outputs.
    task automatic compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, " queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " value_valid"},  32'(value_valid),  32'(e.kind == K_VAL));
        check({tag, " err_overflow"}, 32'(err_overflow), 32'(e.kind == K_OVF));
        check({tag, " err_char"},     32'(err_char),     32'(e.kind == K_CHR));
        check({tag, " value_out"},    32'(value_out),    e.value);
        check({tag, " busy"},         32'(busy),         32'(e.busy));
    endtask

    // One clock of stimulus; the byte is classified the way the upstream stage would.
    task automatic step(input string tag, input logic e, input byte c, input logic fl,
                        input kind_t k, input int unsigned v, input logic b);
        @(negedge clk);
        en        = e;
        data_in   = c;
        is_number = e && (c >= "0") && (c <= "9");
        is_white  = e && ((c == " ") || (c == "-"));
        flush     = fl;
        exp_q.push_back('{kind: k, value: v, busy: b});
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic hold_reset(input string tag, input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            exp_q.push_back('{kind: K_NONE, value: 0, busy: 1'b0});
            @(posedge clk);
            #1;
            compare(tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        data_in   = 8'h00;
        is_number = 1'b0;
        is_white  = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('{kind: K_NONE, value: 0, busy: 1'b0});
        compare("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("idle",  0, " ", 0, K_NONE, 0, 0);

        // "123 "
        step("t1_1",  1, "1", 0, K_NONE, 0,   1);
        step("t1_2",  1, "2", 0, K_NONE, 0,   1);
        step("t1_3",  1, "3", 0, K_NONE, 0,   1);
        step("t1_sp", 1, " ", 0, K_VAL,  123, 0);
        step("t1_hd", 0, " ", 0, K_NONE, 123, 0);

        // "65535 65536 "
        step("t2_a6", 1, "6", 0, K_NONE, 123,   1);
        step("t2_a5", 1, "5", 0, K_NONE, 123,   1);
        step("t2_b5", 1, "5", 0, K_NONE, 123,   1);
        step("t2_a3", 1, "3", 0, K_NONE, 123,   1);
        step("t2_c5", 1, "5", 0, K_NONE, 123,   1);
        step("t2_sp", 1, " ", 0, K_VAL,  65535, 0);
        step("t2_d6", 1, "6", 0, K_NONE, 65535, 1);
        step("t2_d5", 1, "5", 0, K_NONE, 65535, 1);
        step("t2_e5", 1, "5", 0, K_NONE, 65535, 1);
        step("t2_b3", 1, "3", 0, K_NONE, 65535, 1);
        step("t2_e6", 1, "6", 0, K_NONE, 65535, 1);
        step("t2_ov", 1, " ", 0, K_OVF,  65535, 0);

        // "4a5 9 "
        step("t3_4",  1, "4", 0, K_NONE, 65535, 1);
        step("t3_a",  1, "a", 0, K_NONE, 65535, 1);
        step("t3_5",  1, "5", 0, K_NONE, 65535, 1);
        step("t3_ce", 1, " ", 0, K_CHR,  65535, 0);
        step("t3_9",  1, "9", 0, K_NONE, 65535, 1);
        step("t3_sp", 1, " ", 0, K_VAL,  9,     0);

        // "  -42-"
        step("t4_s1", 1, " ", 0, K_NONE, 9,  0);
        step("t4_s2", 1, " ", 0, K_NONE, 9,  0);
        step("t4_d1", 1, "-", 0, K_NONE, 9,  0);
        step("t4_4",  1, "4", 0, K_NONE, 9,  1);
        step("t4_2",  1, "2", 0, K_NONE, 9,  1);
        step("t4_d2", 1, "-", 0, K_VAL,  42, 0);

        // "88" then '1' with flush, then a lone flush
        step("t5_8a", 1, "8", 0, K_NONE, 42,  1);
        step("t5_8b", 1, "8", 0, K_NONE, 42,  1);
        step("t5_1f", 1, "1", 1, K_VAL,  881, 0);
        step("t5_fl", 0, " ", 1, K_NONE, 881, 0);

        // "12" with an en-low gap, then '7' with flush
        step("t6_1",  1, "1", 0, K_NONE, 881, 1);
        step("t6_gp", 0, " ", 0, K_NONE, 881, 1);
        step("t6_2",  1, "2", 0, K_NONE, 881, 1);
        step("t6_7f", 1, "7", 1, K_VAL,  127, 0);

        // Leading zeros; bad byte terminated by flush alone
        step("t7_0a", 1, "0", 0, K_NONE, 127, 1);
        step("t7_0b", 1, "0", 0, K_NONE, 127, 1);
        step("t7_7",  1, "7", 0, K_NONE, 127, 1);
        step("t7_sp", 1, " ", 0, K_VAL,  7,   0);
        step("t7_x",  1, "x", 0, K_NONE, 7,   1);
        step("t7_fl", 0, " ", 1, K_CHR,  7,   0);

        // "567", reset mid-run, then "3 "
        step("t8_5",  1, "5", 0, K_NONE, 7, 1);
        step("t8_6",  1, "6", 0, K_NONE, 7, 1);
        step("t8_7",  1, "7", 0, K_NONE, 7, 1);
        hold_reset("t8_rst", 2);
        step("t8_3",  1, "3", 0, K_NONE, 0, 1);
        step("t8_sp", 1, " ", 0, K_VAL,  3, 0);
        step("t8_hd", 0, " ", 0, K_NONE, 3, 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/number_assembler.md
# number_assembler

Downstream stage of the byte classifier in the data sniffer path. Consumes the classified byte stream (byte plus `is_number` / `is_white` flags) and assembles runs of ASCII decimal digits into unsigned binary values. A run ends at a separator byte or a flush, and the block then emits one value per run with a single-cycle valid pulse. Malformed runs (non-digit, non-separator byte, or overflow) are discarded and flagged instead of emitted.

## Interface
- `WIDTH`, 16, width of the assembled value; the maximum representable value is 2^WIDTH-1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  byte strobe; `data_in`, `is_number` and `is_white` are valid when high.
- `data_in`  in  8  classified ASCII byte.
- `is_number`  in  1  byte is '0'..'9'.
- `is_white`  in  1  byte is a separator (' ' or '-').
- `flush`  in  1  end-of-stream; terminates any run in progress.
- `value_out`  out  WIDTH  last assembled value; holds until the next emit.
- `value_valid`  out  1  one-cycle pulse when `value_out` is updated.
- `err_overflow`  out  1  one-cycle pulse when a run is terminated after exceeding 2^WIDTH-1.
- `err_char`  out  1  one-cycle pulse when a run is terminated after containing a bad byte.
- `busy`  out  1  high while state is ACCUM or DISCARD.

## Operation
- Byte classes when `en`=1:
  - digit: `is_number`=1.
  - separator: `is_white`=1.
  - bad: neither flag set.
  - If both flags are set, the byte is treated as a digit.
- Digit value is `data_in - 8'd48`, 4 bits.
- States: IDLE, ACCUM, DISCARD. Internal accumulator `acc` is WIDTH bits. Sticky flag `ovf_seen` records which error caused DISCARD.
- IDLE:
  - digit: `acc` = digit, go to ACCUM.
  - separator: stay in IDLE, no output.
  - bad: go to DISCARD with `ovf_seen`=0.
- ACCUM:
  - digit: compute `acc*10 + digit` in WIDTH+4 bits.
    - Result ≤ 2^WIDTH-1: store it.
    - Otherwise: go to DISCARD with `ovf_seen`=1.
  - separator: `value_out` = `acc`, pulse `value_valid`, go to IDLE.
  - bad: go to DISCARD with `ovf_seen`=0.
- DISCARD:
  - digit or bad: stay in DISCARD; `ovf_seen` is unchanged.
  - separator: pulse `err_overflow` if `ovf_seen`=1, else pulse `err_char`; go to IDLE.
- `flush`=1 acts as a separator applied after the same-cycle byte (if `en`=1) is processed.
  - Example: digit '7' with flush from ACCUM `acc`=12 emits 127.
  - Flush in IDLE with no byte produces no output.
- Leading zeros are accepted: "007" emits 7.
- `value_valid`, `err_overflow` and `err_char` are mutually exclusive in any cycle.

## Timing
- Reset values: state IDLE, `acc`=0, `ovf_seen`=0, `value_out`=0, `value_valid`=0, `err_overflow`=0, `err_char`=0, `busy`=0.
- Latency: the terminating separator or flush is sampled at edge N. `value_out`, `value_valid` and the error pulses are registered and visible after edge N.
- Pulses last exactly one cycle. Back-to-back runs (e.g. "1 2 " on consecutive cycles) produce pulses on non-adjacent cycles only because the separators are spaced; no throughput stall exists.
- Every `en` cycle is consumed; the block has no backpressure.
- `en`=0 with `flush`=0: all state and `value_out` hold; pulses deassert.
- Reset mid-run: any partial `acc` is dropped and no pulse is emitted. The first digit after `rst_n` deasserts starts a fresh run.
- Overflow boundary at `WIDTH`=16: "65535" emits 65535; "65536" gives `err_overflow`.

## Test plan
- "123 " on consecutive `en` cycles -> after the space's edge, `value_out`=123 with `value_valid` high for one cycle; `busy` drops at the same edge.
- "65535 65536 " -> first 65535 with `value_valid`, then an `err_overflow` pulse; `value_out` stays 65535.
- "4a5 9 " -> `err_char` pulse at the first space, then `value_out`=9 with `value_valid`.
- "  -42-" -> leading separators are ignored; `value_out`=42 emitted at the trailing '-'; the leading '-' produces no output.
- "88" then '1' with `flush` in the same cycle -> `value_out`=881 with `value_valid`; a following `flush` alone produces no pulse.
- "567" then `rst_n` low for 2 cycles, then "3 " -> no pulse during or after reset; `value_out`=0 after reset, then 3 emitted.
